// File: rtl/jtag_dr_pkg.sv
// Shared types and helpers for the JTAG DR bridge.
// Optional build macro used by this slice: JTAG_DR_LEN_CHECK_EN.
package jtag_dr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2
  } jtag_state_e;

  localparam int WIDTH_MIN   = 2;
  localparam int WIDTH_MAX   = 64;
  localparam int NUM_CH_MAX  = 8;
  localparam int SYNC_MIN    = 2;
  localparam int SYNC_MAX    = 4;

  // Channel index width; a single channel still gets a 1-bit select.
  function automatic int sel_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/jtag_dr_bridge_if.sv
// Output side of the JTAG DR bridge: captured word, valid/ready, overflow status.
// dr_len_err exists only when JTAG_DR_LEN_CHECK_EN is defined.
interface jtag_dr_bridge_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 1
);
  logic [WIDTH-1:0] dr_data;
  logic [SEL_W-1:0] dr_sel;
  logic             dr_valid;
  logic             dr_ready;
  logic             dr_overflow;
  logic             ovf_clr;
`ifdef JTAG_DR_LEN_CHECK_EN
  logic             dr_len_err;
`endif

  modport master (
`ifdef JTAG_DR_LEN_CHECK_EN
    output dr_len_err,
`endif
    output dr_data, dr_sel, dr_valid, dr_overflow,
    input  dr_ready, ovf_clr
  );

  modport slave (
`ifdef JTAG_DR_LEN_CHECK_EN
    input  dr_len_err,
`endif
    input  dr_data, dr_sel, dr_valid, dr_overflow,
    output dr_ready, ovf_clr
  );
endinterface

// File: rtl/jtag_sync.sv
// Multi-flop synchroniser for asynchronous JTAG inputs with per-bit edge detect.
// rise/fall are single-cycle pulses relative to the synchronised level.
module jtag_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [STAGES-1:0][W-1:0] stage_reg;
  logic [W-1:0]             prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= '0;
      prev_reg  <= '0;
    end else begin
      stage_reg <= {stage_reg[STAGES-2:0], d};
      prev_reg  <= stage_reg[STAGES-1];
    end
  end

  assign q    = stage_reg[STAGES-1];
  assign rise = q & ~prev_reg;
  assign fall = ~q & prev_reg;
endmodule

// File: rtl/jtag_dr_bridge.sv
// JTAGG user-DR bridge: captures/shifts NUM_CH registers in the clk domain and
// hands updated words out over valid/ready. Optional macro: JTAG_DR_LEN_CHECK_EN.
module jtag_dr_bridge
  import jtag_dr_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    jtck,
  input  logic                    jtdi,
  input  logic                    jshift,
  input  logic                    jupdate,
  input  logic                    jrstn,
  input  logic [NUM_CH-1:0]       jce,
  output logic [NUM_CH-1:0]       jtdo,
  input  logic [WIDTH*NUM_CH-1:0] rd_data,
  jtag_dr_bridge_if.master        dr
);
  localparam int SEL_W = sel_width(NUM_CH);
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam int VEC_W = NUM_CH + 4;

  logic tck_re, tck_fe, tck_lvl_unused;
  logic [VEC_W-1:0] jvec_s, jvec_rise_unused, jvec_fall_unused;

  jtag_sync #(.W(1), .STAGES(SYNC_STAGES)) u_tck_sync (
    .clk(clk), .rst(rst), .d(jtck),
    .q(tck_lvl_unused), .rise(tck_re), .fall(tck_fe)
  );

  jtag_sync #(.W(VEC_W), .STAGES(SYNC_STAGES)) u_jvec_sync (
    .clk(clk), .rst(rst), .d({jce, jrstn, jupdate, jshift, jtdi}),
    .q(jvec_s), .rise(jvec_rise_unused), .fall(jvec_fall_unused)
  );

  logic              jtdi_s, jshift_s, jupdate_s, jrstn_s;
  logic [NUM_CH-1:0] jce_s;
  assign jtdi_s    = jvec_s[0];
  assign jshift_s  = jvec_s[1];
  assign jupdate_s = jvec_s[2];
  assign jrstn_s   = jvec_s[3];
  assign jce_s     = jvec_s[VEC_W-1:4];

  logic [WIDTH-1:0] rd_words [NUM_CH];
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rd
    assign rd_words[gi] = rd_data[gi*WIDTH +: WIDTH];
  end

  logic             ce_any;
  logic [SEL_W-1:0] ce_idx;
  always_comb begin
    ce_any = |jce_s;
    ce_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (jce_s[i]) ce_idx = SEL_W'(i);
    end
  end

  jtag_state_e      state_reg;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic [CNT_W-1:0] bitcnt_reg, bitcnt_next;
  logic [SEL_W-1:0] ch_reg;
  logic             upd_pulse_reg;
  logic [WIDTH-1:0] upd_data_reg;
  logic [SEL_W-1:0] upd_sel_reg;
`ifdef JTAG_DR_LEN_CHECK_EN
  logic             upd_len_ok_reg;
`endif

  assign sr_next     = {jtdi_s, sr_reg[WIDTH-1:1]};
  assign bitcnt_next = (bitcnt_reg == CNT_W'(WIDTH + 1)) ? bitcnt_reg : bitcnt_reg + 1'b1;

  // The edge that moves CAPTURE->SHIFT is already a shift edge, so a
  // WIDTH-bit transfer needs exactly WIDTH rising edges with jshift high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sr_reg        <= '0;
      bitcnt_reg    <= '0;
      ch_reg        <= '0;
      upd_pulse_reg <= 1'b0;
      upd_data_reg  <= '0;
      upd_sel_reg   <= '0;
`ifdef JTAG_DR_LEN_CHECK_EN
      upd_len_ok_reg <= 1'b0;
`endif
    end else begin
      upd_pulse_reg <= 1'b0;
      if (!jrstn_s) begin
        state_reg  <= IDLE;
        sr_reg     <= '0;
        bitcnt_reg <= '0;
      end else if (tck_re) begin
        if (jupdate_s) begin
          upd_pulse_reg <= 1'b1;
          upd_data_reg  <= sr_reg;
          upd_sel_reg   <= ch_reg;
`ifdef JTAG_DR_LEN_CHECK_EN
          upd_len_ok_reg <= (bitcnt_reg == CNT_W'(WIDTH));
`endif
          state_reg     <= IDLE;
          bitcnt_reg    <= '0;
        end else begin
          case (state_reg)
            IDLE: if (ce_any && !jshift_s) begin
              state_reg  <= CAPTURE;
              ch_reg     <= ce_idx;
              sr_reg     <= rd_words[ce_idx];
              bitcnt_reg <= '0;
            end
            CAPTURE: if (jshift_s) begin
              state_reg  <= SHIFT;
              sr_reg     <= sr_next;
              bitcnt_reg <= bitcnt_next;
            end else if (!ce_any) begin
              state_reg <= IDLE;
            end
            SHIFT: if (jshift_s) begin
              sr_reg     <= sr_next;
              bitcnt_reg <= bitcnt_next;
            end else begin
              state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
          endcase
        end
      end
    end
  end

  // TDO changes on the falling edge so the host samples a settled bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      jtdo <= '0;
    end else if (tck_fe) begin
      jtdo         <= '0;
      jtdo[ch_reg] <= sr_reg[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dr.dr_data     <= '0;
      dr.dr_sel      <= '0;
      dr.dr_valid    <= 1'b0;
      dr.dr_overflow <= 1'b0;
`ifdef JTAG_DR_LEN_CHECK_EN
      dr.dr_len_err  <= 1'b0;
`endif
    end else begin
      if (dr.dr_valid && dr.dr_ready) dr.dr_valid <= 1'b0;
      if (dr.ovf_clr) begin
        dr.dr_overflow <= 1'b0;
`ifdef JTAG_DR_LEN_CHECK_EN
        dr.dr_len_err  <= 1'b0;
`endif
      end
      // Later assignments win, so a new error beats a same-cycle clear.
      if (upd_pulse_reg) begin
`ifdef JTAG_DR_LEN_CHECK_EN
        if (!upd_len_ok_reg) dr.dr_len_err <= 1'b1;
        else
`endif
        if (!dr.dr_valid || dr.dr_ready) begin
          dr.dr_data  <= upd_data_reg;
          dr.dr_sel   <= upd_sel_reg;
          dr.dr_valid <= 1'b1;
        end else begin
          dr.dr_overflow <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_jtag_dr_bridge.sv
// Directed bench for jtag_dr_bridge: bit-bangs JTAGG-style TCK cycles and
// checks TDO streams and the output handshake against hand-computed words.
module tb_jtag_dr_bridge;
  localparam int WIDTH  = 32;
  localparam int NUM_CH = 2;
  localparam int SYNC   = 2;
  localparam int HALF   = 5;   // clk cycles per TCK half-period

  logic              clk = 1'b0;
  logic              rst;
  logic              jtck, jtdi, jshift, jupdate, jrstn;
  logic [NUM_CH-1:0] jce;
  logic [NUM_CH-1:0] jtdo;
  logic [WIDTH*NUM_CH-1:0] rd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jtag_dr_bridge_if #(.WIDTH(WIDTH), .SEL_W(1)) dr_if ();

  jtag_dr_bridge #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .jtck(jtck), .jtdi(jtdi), .jshift(jshift),
    .jupdate(jupdate), .jrstn(jrstn), .jce(jce), .jtdo(jtdo),
    .rd_data(rd_data), .dr(dr_if)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tck_cycle(input logic tdi, input logic shift, input logic upd,
                           input logic [NUM_CH-1:0] ce, output logic [NUM_CH-1:0] tdo);
    jtdi = tdi; jshift = shift; jupdate = upd; jce = ce;
    repeat (HALF) @(posedge clk);
    #1 tdo = jtdo; jtck = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 jtck = 1'b0;
  endtask

  // Capture cycle followed by nbits shift cycles; collects TDO of channel tsel.
  task automatic shift_in(input logic [NUM_CH-1:0] ce, input int tsel,
                          input logic [WIDTH-1:0] wdata, input int nbits,
                          output logic [WIDTH-1:0] tdo_word, output logic other_seen);
    logic [NUM_CH-1:0] t;
    tck_cycle(1'b0, 1'b0, 1'b0, ce, t);
    tdo_word   = '0;
    other_seen = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      tck_cycle((i < WIDTH) ? wdata[i] : 1'b0, 1'b1, 1'b0, ce, t);
      if (i < WIDTH) tdo_word[i] = t[tsel];
      for (int k = 0; k < NUM_CH; k++) if (k != tsel && t[k]) other_seen = 1'b1;
    end
    jshift = 1'b0; jce = '0;
  endtask

  // Update cycle; optionally pulses dr_ready in the cycle the word is offered.
  task automatic do_update(input logic ready_pulse, output logic valid_at_lat);
    jtdi = 1'b0; jshift = 1'b0; jupdate = 1'b1; jce = '0;
    repeat (HALF) @(posedge clk);
    #1 jtck = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    #1 if (ready_pulse) dr_if.dr_ready = 1'b1;
    @(posedge clk);
    #1 dr_if.dr_ready = 1'b0;
    valid_at_lat = dr_if.dr_valid;
    repeat (HALF - SYNC - 2) @(posedge clk);
    #1 jtck = 1'b0; jupdate = 1'b0;
    repeat (2 * HALF) @(posedge clk);
    #1;
  endtask

  task automatic consume();
    @(posedge clk); #1 dr_if.dr_ready = 1'b1;
    @(posedge clk); #1 dr_if.dr_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 dr_if.ovf_clr = 1'b1;
    @(posedge clk); #1 dr_if.ovf_clr = 1'b0;
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] tw;
    logic oth, v;
    rst = 1'b1; jtck = 1'b0; jtdi = 1'b0; jshift = 1'b0; jupdate = 1'b0;
    jrstn = 1'b1; jce = '0; dr_if.dr_ready = 1'b0; dr_if.ovf_clr = 1'b0;
    rd_data = {32'hCAFEF00D, 32'h11112222};
    repeat (4) @(posedge clk);
    #1;
    chk("rst_data",  64'(dr_if.dr_data), 64'h0);
    chk("rst_valid", 64'(dr_if.dr_valid), 64'h0);
    chk("rst_ovf",   64'(dr_if.dr_overflow), 64'h0);
    chk("rst_sel",   64'(dr_if.dr_sel), 64'h0);
    chk("rst_jtdo",  64'(jtdo), 64'h0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Full ch1 transfer
    shift_in(2'b10, 1, 32'h12345678, 32, tw, oth);
    chk("t1_tdo_stream", 64'(tw), 64'hCAFEF00D);
    chk("t1_tdo0_quiet", 64'(oth), 64'h0);
    do_update(1'b0, v);
    chk("t1_valid_lat", 64'(v), 64'h1);
    chk("t1_data", 64'(dr_if.dr_data), 64'h12345678);
    chk("t1_sel",  64'(dr_if.dr_sel), 64'h1);
    chk("t1_ovf",  64'(dr_if.dr_overflow), 64'h0);
    consume();
    @(posedge clk); #1;
    chk("t1_valid_drop", 64'(dr_if.dr_valid), 64'h0);

    // Overflow: second word dropped while the first is held
    shift_in(2'b01, 0, 32'h1, 32, tw, oth);
    do_update(1'b0, v);
    chk("t2_first_valid", 64'(v), 64'h1);
    shift_in(2'b01, 0, 32'h2, 32, tw, oth);
    do_update(1'b0, v);
    chk("t2_data_held", 64'(dr_if.dr_data), 64'h1);
    chk("t2_ovf_set",   64'(dr_if.dr_overflow), 64'h1);
    chk("t2_valid",     64'(dr_if.dr_valid), 64'h1);
    pulse_clr();
    @(posedge clk); #1;
    chk("t2_ovf_clr", 64'(dr_if.dr_overflow), 64'h0);

    // Handshake and update in the same cycle
    shift_in(2'b01, 0, 32'hAA, 32, tw, oth);
    do_update(1'b1, v);
    chk("t3_valid_lat", 64'(v), 64'h1);
    chk("t3_data",  64'(dr_if.dr_data), 64'hAA);
    chk("t3_valid", 64'(dr_if.dr_valid), 64'h1);
    chk("t3_ovf",   64'(dr_if.dr_overflow), 64'h0);

    // Both jce bits: lowest channel wins
    consume();
    shift_in(2'b11, 0, 32'h5A5A0F0F, 32, tw, oth);
    chk("t4_tdo_stream", 64'(tw), 64'h11112222);
    do_update(1'b0, v);
    chk("t4_data", 64'(dr_if.dr_data), 64'h5A5A0F0F);
    chk("t4_sel",  64'(dr_if.dr_sel), 64'h0);

    // TAP reset mid-shift; held word survives, next transfer is clean
    shift_in(2'b10, 1, 32'hFFFFFFFF, 10, tw, oth);
    @(posedge clk); #1 jrstn = 1'b0;
    repeat (8) @(posedge clk); #1 jrstn = 1'b1;
    repeat (8) @(posedge clk); #1;
    chk("t5_held_valid", 64'(dr_if.dr_valid), 64'h1);
    chk("t5_held_data",  64'(dr_if.dr_data), 64'h5A5A0F0F);
    consume();
    shift_in(2'b10, 1, 32'hDEADBEEF, 32, tw, oth);
    chk("t5_tdo_stream", 64'(tw), 64'hCAFEF00D);
    do_update(1'b0, v);
    chk("t5_data", 64'(dr_if.dr_data), 64'hDEADBEEF);
    chk("t5_sel",  64'(dr_if.dr_sel), 64'h1);

    // System reset mid-shift with overflow set and TDO high
    shift_in(2'b01, 0, 32'h77, 32, tw, oth);
    do_update(1'b0, v);
    chk("t6_pre_ovf", 64'(dr_if.dr_overflow), 64'h1);
    rd_data = {32'hFFFFFFFF, 32'h11112222};
    shift_in(2'b10, 1, 32'h0, 10, tw, oth);
    repeat (4) @(posedge clk); #1;
    chk("t6_pre_jtdo", 64'(jtdo), 64'h2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_data",  64'(dr_if.dr_data), 64'h0);
    chk("t6_sel",   64'(dr_if.dr_sel), 64'h0);
    chk("t6_valid", 64'(dr_if.dr_valid), 64'h0);
    chk("t6_ovf",   64'(dr_if.dr_overflow), 64'h0);
    chk("t6_jtdo",  64'(jtdo), 64'h0);
    rst = 1'b0;
    repeat (8) @(posedge clk); #1;
    shift_in(2'b01, 0, 32'h600DF00D, 32, tw, oth);
    chk("t6_post_tdo", 64'(tw), 64'h11112222);
    do_update(1'b0, v);
    chk("t6_post_data", 64'(dr_if.dr_data), 64'h600DF00D);
    consume();

`ifdef JTAG_DR_LEN_CHECK_EN
    shift_in(2'b01, 0, 32'h3, 31, tw, oth);
    do_update(1'b0, v);
    chk("t7_short_valid", 64'(dr_if.dr_valid), 64'h0);
    chk("t7_short_err",   64'(dr_if.dr_len_err), 64'h1);
    pulse_clr();
    @(posedge clk); #1;
    chk("t7_err_clr", 64'(dr_if.dr_len_err), 64'h0);
    shift_in(2'b01, 0, 32'h3, 33, tw, oth);
    do_update(1'b0, v);
    chk("t7_long_valid", 64'(dr_if.dr_valid), 64'h0);
    chk("t7_long_err",   64'(dr_if.dr_len_err), 64'h1);
`else
    // 31 shifts: bit 0 keeps readback bit 31 (0), upper bits hold 3 << 1
    shift_in(2'b01, 0, 32'h3, 31, tw, oth);
    do_update(1'b0, v);
    chk("t7_short_valid", 64'(dr_if.dr_valid), 64'h1);
    chk("t7_short_data",  64'(dr_if.dr_data), 64'h6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jtag_dr_bridge.md
Name: jtag_dr_bridge

Overview:
Parametrised successor to the single 32-bit, two-register, write-only JTAG DR capture logic in the FPGA top level.
- Bridges NUM_CH user data registers behind the ECP5 JTAGG primitive into the clk domain.
- Adds TDO readback, configurable width, metastability synchronisers and a valid/ready output handshake with overflow detection.
- Sits in the FPGA top between JTAGG and the SOC debug register ports.

Parameters:
WIDTH, 32, DR length in bits (2..64)
NUM_CH, 2, number of JCE-selected registers (1..2 on JTAGG; logic supports 1..8)
SYNC_STAGES, 2, flops per synchroniser (2..4)

Ports:
clk  in  1  system clock; must be at least 8x the JTCK frequency
rst  in  1  synchronous, active-high reset
jtck  in  1  JTAGG JTCK (asynchronous)
jtdi  in  1  JTAGG JTDI
jshift  in  1  JTAGG JSHIFT
jupdate  in  1  JTAGG JUPDATE
jrstn  in  1  JTAGG JRSTN, active-low TAP reset
jce  in  NUM_CH  JTAGG JCE1/JCE2..., one-hot channel enable
jtdo  out  NUM_CH  to JTAGG JTDO1/JTDO2...
rd_data  in  WIDTH*NUM_CH  per-channel readback words, ch0 at LSBs; sampled at capture
dr_data  out  WIDTH  last updated word
dr_sel  out  $clog2(NUM_CH) (min 1)  channel index of dr_data
dr_valid  out  1  word available
dr_ready  in  1  consumer accepts word
dr_overflow  out  1  sticky: an update was lost
ovf_clr  in  1  clears dr_overflow

Behaviour:
- Reset values: dr_data=0, dr_sel=0, dr_valid=0, dr_overflow=0, jtdo=0, shift reg=0, state=IDLE.
- Sync: every J* input passes through SYNC_STAGES flops. A TCK rising edge (tck_re) is the synced 0->1 transition; a falling edge (tck_fe) is 1->0. All J* sampling uses values registered on tck_re. Latency from the real TCK edge to the internal event is SYNC_STAGES+1 clk.
- jrstn synced low: shift reg, bit count and state go to IDLE on the next clk. Output holding regs (dr_data/dr_valid/dr_overflow) are NOT cleared.
- FSM IDLE/CAPTURE/SHIFT, advanced only on tck_re:
  - IDLE: any jce bit high with jshift=0 -> CAPTURE. Latch active channel ch = index of the lowest set jce bit. Load the shift reg from rd_data[ch].
  - CAPTURE: jshift=1 -> SHIFT; jce all 0 -> IDLE.
  - SHIFT: on each tck_re with jshift=1, shift reg <= {jtdi, sr[WIDTH-1:1]} (LSB first) and bitcnt++ saturating at WIDTH+1. jshift=0 -> IDLE.
  - Any state, jupdate=1 on tck_re -> update event. FSM -> IDLE and bitcnt=0.
- jtdo[ch] = sr[0], re-registered on tck_fe so TDO is stable across the rising edge. Non-selected jtdo bits = 0.
- Update event with dr_valid=0, or dr_valid=1 and dr_ready=1 in the same cycle: dr_data<=sr, dr_sel<=ch, dr_valid<=1.
- Update event with dr_valid=1 and dr_ready=0: word dropped, dr_overflow<=1, held data unchanged.
- dr_valid falls one cycle after a dr_valid&dr_ready handshake unless a new update loads in the same cycle.
- ovf_clr and a new overflow in the same cycle: overflow wins (stays 1).
- jce with more than one bit set: lowest index wins.

Optional Feature:
JTAG_DR_LEN_CHECK_EN
- Defined: an update is accepted only if bitcnt==WIDTH. Otherwise it is discarded and adds output dr_len_err (1 bit, sticky, cleared by ovf_clr, reset 0).
- Undefined: updates are accepted regardless of bit count (short shifts leave high bits partially from readback), and the port is absent.

Decomposition:
- Shared package jtag_dr_pkg: FSM state enum (IDLE=0, CAPTURE=1, SHIFT=2), localparam SEL_W derivation, WIDTH limits.
- One sub-module jtag_sync: SYNC_STAGES-deep synchroniser plus rise/fall edge detect, instantiated for jtck, and a vector variant for the other inputs.

Test Plan:
- WIDTH=32, NUM_CH=2. Capture ch1 with rd_data[1]=0xCAFEF00D, shift 32 bits of 0x12345678 LSB-first, then update -> jtdo[1] streams 0xCAFEF00D LSB-first; dr_data=0x12345678, dr_sel=1, dr_valid=1 within SYNC_STAGES+2 clk of the update edge.
- dr_ready=0, two back-to-back updates (0x1, then 0x2) -> dr_data stays 0x1 and dr_overflow=1. Pulse ovf_clr -> overflow 0.
- dr_valid=1 and dr_ready=1 in the same cycle as an update of 0xAA -> dr_data=0xAA, dr_valid stays 1, no overflow.
- jrstn pulsed low mid-shift after 10 bits -> FSM IDLE and the next full transfer decodes correctly; a previously held dr_valid word survives.
- rst asserted mid-shift -> all outputs return to reset values on the next clk.
- With JTAG_DR_LEN_CHECK_EN: a 31-bit shift then update -> dr_valid stays 0, dr_len_err=1. A 33-bit shift -> also rejected.
